// File: rtl/stack_seq_pkg.sv
// Shared types and encodings for the stack sequencer: FSM states, select codes,
// and the per-state control word decoder.
package stack_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, INT_WAIT,
    C_PC1, C_PC2,
    I_PC1, I_PC2, I_CCR,
    R_PC2, R_PC1,
    T_CCR, T_PC2, T_PC1
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_PC1  = 2'b01;
  localparam logic [1:0] SEL_PC2  = 2'b10;
  localparam logic [1:0] SEL_CCR  = 2'b11;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_POP  = 2'b01;
  localparam logic [1:0] PC_VEC  = 2'b10;
  localparam logic [1:0] PC_CALL = 2'b11;

  typedef struct packed {
    logic       mem_wr;
    logic       mem_rd;
    logic [1:0] data_sel;
    logic [1:0] pop_sel;
    logic [1:0] pc_sel;
    logic       freeze_pc;
    logic       freeze_cu;
    logic       flush;
    logic       busy;
  } ctl_t;

  // Moore output decode; the last state of each chain releases the PC and flushes.
  function automatic ctl_t state_ctl(state_t s);
    ctl_t c;
    c = '0;
    if (s != IDLE) begin
      c.busy      = 1'b1;
      c.freeze_cu = 1'b1;
      c.freeze_pc = 1'b1;
    end
    case (s)
      INT_WAIT: begin c.freeze_cu = 1'b0; c.freeze_pc = 1'b0; end
      C_PC1: begin c.mem_wr = 1'b1; c.data_sel = SEL_PC1; end
      C_PC2: begin
        c.mem_wr = 1'b1; c.data_sel = SEL_PC2;
        c.pc_sel = PC_CALL; c.flush = 1'b1; c.freeze_pc = 1'b0;
      end
      I_PC1: begin c.mem_wr = 1'b1; c.data_sel = SEL_PC1; end
      I_PC2: begin c.mem_wr = 1'b1; c.data_sel = SEL_PC2; end
      I_CCR: begin
        c.mem_wr = 1'b1; c.data_sel = SEL_CCR;
        c.pc_sel = PC_VEC; c.flush = 1'b1; c.freeze_pc = 1'b0;
      end
      R_PC2: begin c.mem_rd = 1'b1; c.pop_sel = SEL_PC2; end
      R_PC1: begin
        c.mem_rd = 1'b1; c.pop_sel = SEL_PC1;
        c.pc_sel = PC_POP; c.flush = 1'b1; c.freeze_pc = 1'b0;
      end
      T_CCR: begin c.mem_rd = 1'b1; c.pop_sel = SEL_CCR; end
      T_PC2: begin c.mem_rd = 1'b1; c.pop_sel = SEL_PC2; end
      T_PC1: begin
        c.mem_rd = 1'b1; c.pop_sel = SEL_PC1;
        c.pc_sel = PC_POP; c.flush = 1'b1; c.freeze_pc = 1'b0;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stack_ptr_unit.sv
// Stack pointer register: SP names the next free word, pushes address SP,
// pops address SP+1; wrap-around is silent.
module stack_ptr_unit #(
  parameter int              ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = 11'h7FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      sp <= SP_RESET;
    else if (push) sp <= sp - 1'b1;
    else if (pop)  sp <= sp + 1'b1;
  end

  assign addr = push ? sp : (pop ? sp + 1'b1 : '0);

endmodule

// File: rtl/stack_sequencer.sv
// Stack port sequencer: turns call/ret/rti/interrupt into multi-cycle push/pop
// chains and drives the matching pipeline freeze/flush and PC source.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int              ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = 11'h7FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              rti_req,
  input  logic              int_req,
  input  logic              hold,
  output logic              int_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [1:0]        mem_data_sel,
  output logic [1:0]        pop_sel,
  output logic [1:0]        pc_sel,
  output logic              freeze_pc,
  output logic              freeze_cu,
  output logic              flush,
  output logic              busy,
  output logic [ADDR_W-1:0] sp
);

  state_t state, nxt;
  ctl_t   ctl;
  logic   instr_req;

  assign instr_req = call_req | ret_req | rti_req;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (call_req)     nxt = C_PC1;
        else if (ret_req) nxt = R_PC2;
        else if (rti_req) nxt = T_CCR;
        else if (int_req) nxt = hold ? INT_WAIT : I_PC1;
      end
      INT_WAIT: if (!hold) nxt = I_PC1;
      C_PC1:   nxt = C_PC2;
      C_PC2:   nxt = IDLE;
      I_PC1:   nxt = I_PC2;
      I_PC2:   nxt = I_CCR;
      I_CCR:   nxt = IDLE;
      R_PC2:   nxt = R_PC1;
      R_PC1:   nxt = IDLE;
      T_CCR:   nxt = T_PC2;
      T_PC2:   nxt = T_PC1;
      T_PC1:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Control word is registered alongside the state so outputs track it glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ctl   <= '0;
    end else begin
      state <= nxt;
      ctl   <= state_ctl(nxt);
    end
  end

  // Acceptance pulse is issued in the deciding IDLE cycle; gated so reset forces it low.
  assign int_ack = rst & (state == IDLE) & int_req & ~instr_req;

  assign mem_wr       = ctl.mem_wr;
  assign mem_rd       = ctl.mem_rd;
  assign mem_data_sel = ctl.data_sel;
  assign pop_sel      = ctl.pop_sel;
  assign pc_sel       = ctl.pc_sel;
  assign freeze_pc    = ctl.freeze_pc;
  assign freeze_cu    = ctl.freeze_cu;
  assign flush        = ctl.flush;
  assign busy         = ctl.busy;

  stack_ptr_unit #(.ADDR_W(ADDR_W), .SP_RESET(SP_RESET)) u_sp (
    .clk  (clk),
    .rst  (rst),
    .push (ctl.mem_wr),
    .pop  (ctl.mem_rd),
    .sp   (sp),
    .addr (mem_addr)
  );

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Central sequencer for the single data-memory stack port: serializes multi-word push/pop sequences for call, ret, rti and hardware interrupt. It owns the stack pointer. It drives memory address, read/write strobes and data-select, pipeline freeze/flush and PC-source select. It sits beside the decode-stage control logic, which forwards one-cycle request pulses.

## Interface
- ADDR_W, 11, data-memory address width; SP width.
- SP_RESET, 11'h7FF, stack pointer value after reset.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- call_req  in  1  one-cycle pulse: CALL in decode.
- ret_req  in  1  one-cycle pulse: RET in decode.
- rti_req  in  1  one-cycle pulse: RTI in decode.
- int_req  in  1  level interrupt request; held by source until int_ack.
- hold  in  1  LDM second word or load-use stall in flight; defers interrupt entry.
- int_ack  out  1  one-cycle pulse when the interrupt is accepted.
- mem_addr  out  ADDR_W  stack access address.
- mem_wr, mem_rd  out  1 each  stack write/read strobes.
- mem_data_sel  out  2  push source: 00 none, 01 PC word1, 10 PC word2, 11 CCR.
- pop_sel  out  2  pop destination, same encoding; read data is valid in the same cycle (asynchronous-read memory).
- pc_sel  out  2  00 PC+1, 01 popped PC, 10 interrupt vector, 11 call target.
- freeze_pc, freeze_cu, flush  out  1 each  pipeline control.
- busy  out  1  high in any non-IDLE state.
- sp  out  ADDR_W  current stack pointer.

## Operation
- SP points to the next free word. Push: addr=SP, then SP<=SP-1. Pop: addr=SP+1, then SP<=SP+1. Arithmetic is modulo 2^ADDR_W; wrap is silent, with no error flag.
- Moore FSM states: IDLE, INT_WAIT, C_PC1, C_PC2, I_PC1, I_PC2, I_CCR, R_PC2, R_PC1, T_CCR, T_PC2, T_PC1.
- IDLE decision priority: call_req > ret_req > rti_req > int_req. Requests are mutually exclusive by ISA; if more than one pulse arrives, only the highest is served and a bench assertion flags it.
- A decoded instruction outranks an interrupt. int_req stays pending as a level and is evaluated again on the next IDLE cycle.
- Transitions from IDLE:
  - call_req -> C_PC1 -> C_PC2 -> IDLE.
  - ret_req -> R_PC2 -> R_PC1 -> IDLE.
  - rti_req -> T_CCR -> T_PC2 -> T_PC1 -> IDLE.
  - int_req, no instruction request, hold=0: int_ack=1 this cycle -> I_PC1.
  - int_req, no instruction request, hold=1: int_ack=1 this cycle -> INT_WAIT. INT_WAIT stays while hold=1 and goes to I_PC1 when hold=0.
- Interrupt chain: I_PC1 -> I_PC2 -> I_CCR -> IDLE.
- Per-state outputs:
  - Push states (C_*, I_*): mem_wr=1, with mem_data_sel of 01 for *_PC1, 10 for *_PC2, 11 for CCR.
  - Pop states (R_*, T_*): mem_rd=1, with pop_sel following the same encoding.
- All non-IDLE states assert freeze_cu=1 and busy=1. INT_WAIT has no memory strobe and asserts freeze_cu=0, freeze_pc=0, so the held instruction can finish.
- Final state of each chain (C_PC2, I_CCR, R_PC1, T_PC1) asserts flush=1 and freeze_pc=0, with pc_sel of 11, 10, 01, 01 respectively. All other non-IDLE, non-INT_WAIT states assert freeze_pc=1.
- Request pulses arriving while busy are ignored; freeze_cu guarantees they cannot occur legitimately.

## Timing
- Request sampled in cycle N; first access in N+1.
- Sequence lengths:
  - call and ret: 2 cycles.
  - rti: 3 cycles.
  - interrupt: 3 cycles plus 1 IDLE acceptance cycle plus any INT_WAIT cycles.
- IDLE is re-entered the cycle after the final state. A pending int_req can be accepted in that same IDLE cycle.
- SP update is registered on the edge that ends each access cycle.
- Reset values (rst=0, any cycle, including mid-sequence):
  - State IDLE, sp=SP_RESET.
  - Every other output 0: mem_addr=0, all strobes 0, selects 00, int_ack=0.
  - An interrupted sequence is abandoned. An int_req still held high is re-accepted after release.
- Reset release is synchronous to the clk edge; the first decision happens on the first edge with rst=1.

## Structure
- Shared package stack_seq_pkg holds:
  - state enum;
  - 2-bit select codes SEL_NONE/SEL_PC1/SEL_PC2/SEL_CCR;
  - PC_NEXT/PC_POP/PC_VEC/PC_CALL.
- Sub-module stack_ptr_unit: SP register with push/pop increment/decrement and address generation (SP or SP+1). The FSM stays in the top module.

## Test plan
- Reset, call_req at N -> N+1: addr 0x7FF wr sel 01. N+2: addr 0x7FE wr sel 10, pc_sel=11, flush=1. N+3: busy=0, sp=0x7FD.
- Call then ret -> reads at 0x7FE (pop_sel 10), then 0x7FF (pop_sel 01, pc_sel=01, flush=1). Then sp=0x7FF.
- int_req with hold=1 for 3 cycles -> single int_ack, 3 INT_WAIT cycles, then writes 0x7FF/0x7FE/0x7FD with sel 01/10/11 and pc_sel=10. Following rti reads 0x7FD/0x7FE/0x7FF with pop_sel 11/10/01, ending at sp=0x7FF.
- call_req and int_req in the same cycle -> call chain completes first. int_ack in the IDLE cycle right after C_PC2, then the interrupt chain.
- rst=0 asserted during I_PC2 -> all outputs 0 immediately (asynchronous), sp=0x7FF, no further writes after release until a new request.
- ret from reset (sp=0x7FF) -> reads 0x000 then 0x001; sp wraps to 0x001 with no error.
